// File: rtl/gen_arb_pkg.sv
// Shared types and helpers for the generic arbiter family.
package gen_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    localparam int unsigned ONEHOT_MAX_W = 64;

    // OR-encoder: exact for one-hot input, 0 for an all-zero input.
    function automatic int unsigned onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < int'(ONEHOT_MAX_W); i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gen_arb_rr_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The lock bus exists only when GEN_ARB_RR_LOCK_EN is defined.
interface gen_arb_rr_if #(
    parameter int unsigned WID = 16
);
    localparam int unsigned IDX_WID = $clog2(WID);

    logic [WID-1:0]     rqsts;
    logic [WID-1:0]     grnts;
    logic               grnt_vld;
    logic [IDX_WID-1:0] grnt_idx;

`ifdef GEN_ARB_RR_LOCK_EN
    logic [WID-1:0]     lock;

    modport master (output rqsts, output lock, input grnts, input grnt_vld, input grnt_idx);
    modport slave  (input rqsts, input lock, output grnts, output grnt_vld, output grnt_idx);
`else
    modport master (output rqsts, input grnts, input grnt_vld, input grnt_idx);
    modport slave  (input rqsts, output grnts, output grnt_vld, output grnt_idx);
`endif

endinterface

// File: rtl/gen_arb_rr_pick.sv
// Combinational rotating-priority pick: first request at or above ptr,
// otherwise the lowest request overall.
module gen_arb_rr_pick
    import gen_arb_pkg::*;
#(
    parameter int unsigned WID     = 16,
    parameter int unsigned IDX_WID = $clog2(WID)
) (
    input  logic [WID-1:0]     rqsts,
    input  logic [IDX_WID-1:0] ptr,
    output logic [WID-1:0]     pick_oh_c,
    output logic [IDX_WID-1:0] pick_idx_c
);

    logic [WID-1:0] masked;
    logic [WID-1:0] oh_masked;
    logic [WID-1:0] oh_plain;
    logic           found_masked;
    logic           found_plain;

    always_comb begin
        masked       = '0;
        oh_masked    = '0;
        oh_plain     = '0;
        found_masked = 1'b0;
        found_plain  = 1'b0;
        for (int i = 0; i < int'(WID); i++) begin
            masked[i] = rqsts[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < int'(WID); i++) begin
            if (masked[i] && !found_masked) begin
                oh_masked[i] = 1'b1;
                found_masked = 1'b1;
            end
            if (rqsts[i] && !found_plain) begin
                oh_plain[i] = 1'b1;
                found_plain = 1'b1;
            end
        end
        pick_oh_c  = found_masked ? oh_masked : oh_plain;
        pick_idx_c = IDX_WID'(onehot_to_idx(ONEHOT_MAX_W'(pick_oh_c)));
    end

endmodule

// File: rtl/gen_arb_rr_top.sv
// Registered round-robin arbiter. Define GEN_ARB_RR_LOCK_EN to add the
// lock bus, the HOLD state and the MAX_HOLD-bounded hold counter.
module gen_arb_rr_top
    import gen_arb_pkg::*;
#(
    parameter int unsigned WID      = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    gen_arb_rr_if.slave bus
);

    localparam int unsigned IDX_WID = $clog2(WID);

    if (WID < 2) begin : g_bad_wid
        $error("gen_arb_rr_top: WID must be at least 2");
    end
    if (MAX_HOLD > 65535) begin : g_bad_hold
        $error("gen_arb_rr_top: MAX_HOLD out of range");
    end

    arb_state_t         state_q, state_d;
    logic [WID-1:0]     grnts_q, grnts_d;
    logic [IDX_WID-1:0] grnt_idx_q, grnt_idx_d;
    logic [IDX_WID-1:0] ptr_q, ptr_d;
    logic [WID-1:0]     pick_oh_c;
    logic [IDX_WID-1:0] pick_idx_c;
    logic               pick_any_c;
    logic               keep_c;

    assign pick_any_c = |bus.rqsts;

    gen_arb_rr_pick #(
        .WID     (WID),
        .IDX_WID (IDX_WID)
    ) u_pick (
        .rqsts      (bus.rqsts),
        .ptr        (ptr_q),
        .pick_oh_c  (pick_oh_c),
        .pick_idx_c (pick_idx_c)
    );

`ifdef GEN_ARB_RR_LOCK_EN
    localparam int unsigned    HCW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           lock_req_c;
    logic           hold_exit_c;

    // Keep the current grant while its owner requests and locks, up to the bound.
    assign lock_req_c  = bus.rqsts[grnt_idx_q] & bus.lock[grnt_idx_q];
    assign hold_exit_c = !lock_req_c || ((MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LAST));
    assign keep_c      = ((state_q == GNT) && lock_req_c) || ((state_q == HOLD) && !hold_exit_c);

    always_comb begin
        hold_cnt_d = '0;
        if (keep_c) begin
            if (state_q == GNT)  hold_cnt_d = HCW'(1);
            else if (&hold_cnt_q) hold_cnt_d = hold_cnt_q;
            else                  hold_cnt_d = hold_cnt_q + HCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`else
    assign keep_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (keep_c)          state_d = HOLD;
        else if (pick_any_c) state_d = GNT;
    end

    // Next grant and pointer; the pointer moves only on a fresh grant.
    always_comb begin
        grnts_d    = pick_oh_c;
        grnt_idx_d = pick_idx_c;
        ptr_d      = ptr_q;
        if (keep_c) begin
            grnts_d    = grnts_q;
            grnt_idx_d = grnt_idx_q;
        end else if (pick_any_c) begin
            ptr_d = (pick_idx_c == IDX_WID'(WID - 1)) ? '0 : pick_idx_c + IDX_WID'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grnts_q    <= '0;
            grnt_idx_q <= '0;
            ptr_q      <= '0;
        end else begin
            grnts_q    <= grnts_d;
            grnt_idx_q <= grnt_idx_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.grnts    = grnts_q;
    assign bus.grnt_idx = grnt_idx_q;
    assign bus.grnt_vld = (state_q != IDLE);

endmodule

// File: tb/tb_gen_arb_rr_top.sv
// Randomised bench for gen_arb_rr_top at WID=4 (MAX_HOLD=3) and WID=5 (MAX_HOLD=0)
// against a scan-order reference model.
module tb_gen_arb_rr_top;

`ifdef GEN_ARB_RR_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] rq [2];
    logic [4:0] lk [2];

    int n_checks = 0;
    int n_fail   = 0;

    int wid [2] = '{4, 5};
    int mh  [2] = '{3, 0};
    int m_ptr [2];
    int m_g   [2];
    int m_age [2];
    bit m_held[2];

    gen_arb_rr_if #(.WID(4)) bus4 ();
    gen_arb_rr_if #(.WID(5)) bus5 ();

    assign bus4.rqsts = rq[0][3:0];
    assign bus5.rqsts = rq[1];
`ifdef GEN_ARB_RR_LOCK_EN
    assign bus4.lock = lk[0][3:0];
    assign bus5.lock = lk[1];
`endif

    gen_arb_rr_top #(.WID(4), .MAX_HOLD(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    gen_arb_rr_top #(.WID(5), .MAX_HOLD(0)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester found walking ptr, ptr+1, ... with wrap at w.
    function automatic int pick(input logic [4:0] r, input int ptr, input int w);
        for (int j = 0; j < w; j++) begin
            int i;
            i = (ptr + j) % w;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int d);
        m_ptr[d]  = 0;
        m_g[d]    = -1;
        m_age[d]  = 0;
        m_held[d] = 1'b0;
    endtask

    task automatic model_step(input int d);
        bit keep;
        int g;
        keep = 1'b0;
        g    = m_g[d];
        if (LOCK_BUILD && g >= 0) begin
            if (rq[d][g] && lk[d][g])
                keep = !m_held[d] || (mh[d] == 0) || (m_age[d] < mh[d] - 1);
        end
        if (keep) begin
            m_age[d]  = m_held[d] ? m_age[d] + 1 : 1;
            m_held[d] = 1'b1;
        end else begin
            m_held[d] = 1'b0;
            m_age[d]  = 0;
            m_g[d]    = pick(rq[d], m_ptr[d], wid[d]);
            if (m_g[d] >= 0) m_ptr[d] = (m_g[d] + 1) % wid[d];
        end
    endtask

    function automatic logic [31:0] exp_gr(input int d);
        return (m_g[d] >= 0) ? (32'd1 << m_g[d]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_idx(input int d);
        return (m_g[d] >= 0) ? 32'(m_g[d]) : 32'd0;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, "_gr4"},  32'(bus4.grnts),    exp_gr(0));
        check_eq({tag, "_vld4"}, 32'(bus4.grnt_vld), 32'(m_g[0] >= 0));
        check_eq({tag, "_idx4"}, 32'(bus4.grnt_idx), exp_idx(0));
        check_eq({tag, "_gr5"},  32'(bus5.grnts),    exp_gr(1));
        check_eq({tag, "_vld5"}, 32'(bus5.grnt_vld), 32'(m_g[1] >= 0));
        check_eq({tag, "_idx5"}, 32'(bus5.grnt_idx), exp_idx(1));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_step(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    logic [3:0] rot_gr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [4:0] alt_gr [5] = '{5'b00001, 5'b10000, 5'b00001, 5'b10000, 5'b00001};

    initial begin
        int n;
        rst   = 1'b1;
        rq[0] = 5'h0F;
        rq[1] = 5'h1F;
        lk[0] = '0;
        lk[1] = '0;
        model_reset(0);
        model_reset(1);

        // Requests pending while in reset must not produce grants.
        cycle("in_rst");
        check_eq("in_rst_gr4", 32'(bus4.grnts), 32'd0);
        cycle("in_rst2");
        rst = 1'b0;

        // Full rotation at WID=4, alternation across the wrap at WID=5.
        rq[0] = 5'b01111;
        rq[1] = 5'b10001;
        for (int k = 0; k < 5; k++) begin
            cycle("rot");
            check_eq("rot_gr4",  32'(bus4.grnts),    32'(rot_gr[k]));
            check_eq("rot_idx4", 32'(bus4.grnt_idx), 32'(k % 4));
            check_eq("wrap_gr5", 32'(bus5.grnts),    32'(alt_gr[k]));
        end

        // Single-cycle request pulse.
        rq[0] = 5'b00100;
        rq[1] = 5'b00000;
        cycle("pulse");
        check_eq("pulse_gr4", 32'(bus4.grnts), 32'd4);
        rq[0] = '0;
        cycle("pulse_end");
        check_eq("pulse_end_vld4", 32'(bus4.grnt_vld), 32'd0);

        // Permanent lock on index 1: bounded at WID=4, unbounded at WID=5.
        rq[0] = 5'b01111;
        rq[1] = 5'b11111;
        lk[0] = 5'b00010;
        lk[1] = 5'b00010;
        for (int k = 0; k < 14; k++) cycle("lock");
        lk[1] = '0;
        for (int k = 0; k < 4; k++) cycle("unlock5");
        lk[1] = 5'b00010;

        // Async reset while index 1 holds the grant.
        n = 0;
        while (!(m_g[0] == 1 && (m_held[0] || !LOCK_BUILD)) && n < 20) begin
            cycle("wait_hold");
            n++;
        end
        check_eq("wait_hold_bound", 32'(n < 20), 32'd1);
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_all("async_rst");
        check_eq("async_rst_vld4", 32'(bus4.grnt_vld), 32'd0);
        cycle("rst_held");
        rst = 1'b0;
        cycle("post_rst");
        check_eq("post_rst_gr4", 32'(bus4.grnts), 32'd1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            rq[0] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rq[1] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lk[0] = 5'($urandom | $urandom);
            lk[1] = 5'($urandom | $urandom);
            rst   = ($urandom_range(0, 99) == 0);
            cycle("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
